// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32I data-memory responder:
// funct3 size/sign codes, FSM state encoding, byte-lane mask and request record.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef logic [3:0] lane_mask_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } mem_req_t;

    // Unsigned load codes have no store counterpart.
    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: byte enables and store replication from size/offset,
// and load extraction with sign/zero extension. Purely combinational.
module dmem_lane_fmt
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output lane_mask_t  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rword >> {offset, 3'b000};
        be      = 4'b0000;
        wword   = wdata;
        rdata   = '0;

        case (funct3[1:0])
            2'b00: begin
                be    = lane_mask_t'(4'b0001 << offset);
                wword = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = lane_mask_t'(4'b0011 << {offset[1], 1'b0});
                wword = {2{wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = rword;
            F3_BU:   rdata = {24'h0, shifted[7:0]};
            F3_HU:   rdata = {16'h0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding RV32I load/store responder with a fixed wait-state count.
// Build option DMEM_MISALIGN_TRAP_EN: fault misaligned halfword/word accesses instead of aligning down.
//
// state | meaning
// IDLE  | ready for a request (req_ready high once out of reset)
// WAIT  | request captured, down-counting wait states
// RESP  | response presented, held until rsp_ready
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    mem_req_t    req_q;
    mem_req_t    req_in;
    mem_req_t    cur;
    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic [1:0]    off;
    logic          range_err;
    logic          align_err;
    logic          err;
    logic          enter_resp;
    logic [31:0]   rword;
    lane_mask_t    be;
    logic [31:0]   wword;
    logic [31:0]   fmt_rdata;

    assign req_in = {req_we, req_addr, req_wdata, req_funct3};

    // With zero wait states the access completes on the accept edge, so decode the live request.
    always_comb begin
        cur        = (state == IDLE) ? req_in : req_q;
        widx       = cur.addr[AW+1:2];
        range_err  = |cur.addr[31:AW+2];
`ifdef DMEM_MISALIGN_TRAP_EN
        off        = cur.addr[1:0];
        align_err  = ((cur.funct3[1:0] == 2'b01) && cur.addr[0]) ||
                     ((cur.funct3[1:0] == 2'b10) && (cur.addr[1:0] != 2'b00));
`else
        align_err  = 1'b0;
        case (cur.funct3[1:0])
            2'b01:   off = {cur.addr[1], 1'b0};
            2'b10:   off = 2'b00;
            default: off = cur.addr[1:0];
        endcase
`endif
        err        = range_err || align_err || !f3_legal(cur.we, cur.funct3);
        enter_resp = ((state == IDLE) && req_valid && req_ready && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd0));
    end

    assign rword = mem[widx];

    dmem_lane_fmt u_lane_fmt (
        .funct3 (cur.funct3),
        .offset (off),
        .wdata  (cur.wdata),
        .rword  (rword),
        .be     (be),
        .wword  (wword),
        .rdata  (fmt_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_q     <= req_in;
                        req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (err || cur.we) ? '0 : fmt_rdata;
            end
        end
    end

    // Contents survive reset; a reset in WAIT simply never reaches the commit edge.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur.we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vectors plus randomized
// load/store traffic against a byte-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] ref_mem [DEPTH*4];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Architectural view: byte-addressed memory, access size 1/2/4, extension by funct3.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rd, output logic er);
        logic [31:0] size;
        logic [31:0] a;
        logic [31:0] v;
        logic        legal;
        rd = '0;
        er = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !we;
            default:                legal = 1'b0;
        endcase
        size = 32'd1 << f3[1:0];
        if (!legal || addr >= 32'(DEPTH*4)) er = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (addr % size != 0) er = 1'b1;
        a = addr;
`else
        a = addr - (addr % size);
`endif
        if (er) return;
        if (we) begin
            for (int i = 0; i < int'(size); i++) ref_mem[a + 32'(i)] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < int'(size); i++) v = v | (32'(ref_mem[a + 32'(i)]) << (8*i));
            if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int hold,
                          output logic [31:0] got, output logic got_err);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          k;
        int          n;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model(we, addr, wdata, f3, exp_rd, exp_er);
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(WS + 1));
        got     = rsp_rdata;
        got_err = rsp_err;
        check("rdata", rsp_rdata, exp_rd);
        check("err", 32'(rsp_err), 32'(exp_er));
        for (int j = 0; j < hold; j++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_err", 32'(rsp_err), 32'(exp_er));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("release_valid", 32'(rsp_valid), 32'd0);
        check("release_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic        ge;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        for (int w = 0; w < 64; w++) do_txn(1'b1, 32'(w*4), $urandom, 3'b010, 0, got, ge);

        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, got, ge);
        do_txn(1'b0, 32'h10, 32'h0, 3'b010, 0, got, ge);
        check("lw10", got, 32'hDEADBEEF);
        do_txn(1'b1, 32'h11, 32'h0000007F, 3'b000, 0, got, ge);
        do_txn(1'b0, 32'h11, 32'h0, 3'b000, 0, got, ge);
        check("lb11", got, 32'h0000007F);
        do_txn(1'b0, 32'h10, 32'h0, 3'b001, 0, got, ge);
        check("lh10", got, 32'h00007FEF);
        do_txn(1'b0, 32'h13, 32'h0, 3'b100, 0, got, ge);
        check("lbu13", got, 32'h000000DE);
        do_txn(1'b0, 32'h13, 32'h0, 3'b000, 0, got, ge);
        check("lb13", got, 32'hFFFFFFDE);
        do_txn(1'b0, 32'h12, 32'h0, 3'b010, 0, got, ge);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw12_err", 32'(ge), 32'd1);
        check("lw12_rdata", got, 32'd0);
`else
        check("lw12_err", 32'(ge), 32'd0);
        check("lw12_rdata", got, 32'hDEAD7FEF);
`endif

        do_txn(1'b1, 32'h0, 32'hA5A50001, 3'b010, 0, got, ge);
        do_txn(1'b1, 32'h400, 32'h11111111, 3'b010, 0, got, ge);
        check("sw400_err", 32'(ge), 32'd1);
        do_txn(1'b0, 32'h0, 32'h0, 3'b010, 0, got, ge);
        check("lw0_kept", got, 32'hA5A50001);
        do_txn(1'b0, 32'h4, 32'h0, 3'b011, 0, got, ge);
        check("f3_011_err", 32'(ge), 32'd1);
        do_txn(1'b1, 32'h4, 32'h0, 3'b100, 0, got, ge);
        check("sbu_err", 32'(ge), 32'd1);

        do_txn(1'b0, 32'h10, 32'h0, 3'b010, 5, got, ge);

        // Store interrupted by reset while waiting must leave the word untouched.
        do_txn(1'b1, 32'h20, 32'h0BADF00D, 3'b010, 0, got, ge);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_wait_ready", 32'(req_ready), 32'd0);
        check("rst_wait_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_wait_novalid", 32'(rsp_valid), 32'd0);
            check("rst_wait_noready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);
        check("rst_release_valid", 32'(rsp_valid), 32'd0);
        do_txn(1'b0, 32'h20, 32'h0, 3'b010, 0, got, ge);
        check("sw20_discarded", got, 32'h0BADF00D);

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 5) != 0) f3 = legal_f3[$urandom_range(0, 4)];
            else                           f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       addr = 32'h400 + 32'($urandom_range(0, 255));
                1:       addr = 32'h80000000 | 32'($urandom_range(0, 255));
                default: addr = 32'($urandom_range(0, 255));
            endcase
            do_txn(1'($urandom_range(0, 1)), addr, $urandom, f3, $urandom_range(0, 2), got, ge);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra access cycles before response (0..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  core presents load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-aligned (rs2 value).
REQ-010 SHALL have port req_funct3  input  3  RV32I load/store size/sign code.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  core accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  access faulted; no memory side effect.

Function
REQ-015 SHALL use FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept on req_valid && req_ready and capture we/addr/wdata/funct3 in that cycle.
REQ-017 SHALL, on accept, go to WAIT with counter loaded to WAIT_STATES-1, or directly to RESP if WAIT_STATES = 0.
REQ-018 SHALL decrement the WAIT counter each cycle and enter RESP when it is 0.
REQ-019 SHALL assert rsp_valid exactly WAIT_STATES+1 cycles after the accept edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_valid && rsp_ready, then return to IDLE.
REQ-021 SHALL allow only one outstanding request; no accept in the cycle of the response handshake.
REQ-022 SHALL commit a store on entry to RESP, writing only the addressed byte lanes.
REQ-023 SHALL decode funct3 as 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-024 SHALL sign-extend LB/LH and zero-extend LBU/LHU from the addressed lane.
REQ-025 SHALL flag rsp_err for funct3 011/110/111, for store with 100/101, and for word index >= DEPTH_WORDS.
REQ-026 SHALL, on any error, suppress the write and drive rsp_rdata = 0.
REQ-027 SHALL use word index addr[log2(DEPTH_WORDS)+1:2]; addr bits above the window set must be zero, else error.

Reset
REQ-028 SHALL, while rst = 1, force IDLE and drive req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-029 SHALL drive req_ready = 1 in the first cycle after rst deasserts.
REQ-030 SHALL discard any in-flight request on rst, including an uncommitted store.
REQ-031 SHALL NOT clear memory contents on rst.

Configuration
REQ-032 SHALL support macro DMEM_MISALIGN_TRAP_EN.
REQ-033 With DMEM_MISALIGN_TRAP_EN defined, halfword at addr[0] = 1 or word at addr[1:0] != 0 SHALL give rsp_err = 1 and no write.
REQ-034 Without it, SHALL align the address down (clear addr[0] for halfword, addr[1:0] for word), never erroring on alignment.

Structure
REQ-035 SHALL place funct3 encodings, state enum and lane-mask type in package riscv_mem_pkg.
REQ-036 SHALL instantiate one combinational sub-module dmem_lane_fmt for byte-enable generation, store replication and load extraction/extension.

Verification
REQ-037 WAIT_STATES=1: SW 0xDEADBEEF @0x10 then LW @0x10 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-038 After REQ-037: SB 0x7F @0x11 then LB @0x11 -> 0x0000007F; LH @0x10 -> 0x00007FEF sign-extended as 0x00007FEF; LBU @0x13 -> 0x000000DE; LB @0x13 -> 0xFFFFFFDE.
REQ-039 LW @0x12: with macro -> err 1, rdata 0; without macro -> rdata of word @0x10, err 0.
REQ-040 DEPTH_WORDS=256: SW @0x400 -> err 1, later LW @0x0 unchanged; funct3 011 load -> err 1.
REQ-041 Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rdata stable, req_ready 0 throughout; release -> IDLE next cycle.
REQ-042 Assert rst during WAIT of SW 0x12345678 @0x20 -> rsp_valid never rises, word @0x20 keeps prior value, req_ready 1 one cycle after rst falls.
